// File: rtl/color_sensor_pkg.sv
// color_sensor_pkg: shared state/channel types, filter codes and widths
// for the colour-sensor frame sequencer.
package color_sensor_pkg;

    localparam int CNT_W = 21;
    localparam int PCT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_CALC,
        ST_PER_OFF,
        ST_PUBLISH
    } state_e;

    typedef enum logic [1:0] {
        CH_CLEAR = 2'd0,
        CH_RED   = 2'd1,
        CH_GREEN = 2'd2,
        CH_BLUE  = 2'd3
    } chan_e;

    // {s2, s3} filter-select codes
    localparam logic [1:0] SEL_CLEAR = 2'b10;
    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_GREEN = 2'b11;
    localparam logic [1:0] SEL_BLUE  = 2'b01;

    localparam logic [PCT_W-1:0] PCT_TIMEOUT = '1;

    function automatic logic [1:0] filter_sel(input chan_e ch);
        logic [1:0] sel;
        sel = SEL_CLEAR;
        unique case (ch)
            CH_CLEAR: sel = SEL_CLEAR;
            CH_RED:   sel = SEL_RED;
            CH_GREEN: sel = SEL_GREEN;
            CH_BLUE:  sel = SEL_BLUE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/color_frame_sequencer_sync.sv
// sensor_edge_sync: 2-flop synchroniser for the sensor output plus a
// one-cycle rising-edge strobe.
module sensor_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/color_frame_sequencer.sv
// color_frame_sequencer: filter sweep, gated edge counting and percentage
// handshake per frame. Define COLOR_TIMEOUT_EN to add the per_done watchdog.
module color_frame_sequencer
    import color_sensor_pkg::*;
#(
    parameter int GATE_CYCLES   = 1_000_000,
    parameter int SETTLE_CYCLES = 10_000,
    parameter int CNT_SAT       = 5000,
    parameter int PER_TIMEOUT   = 1024
) (
    input  logic             CLK100MHZ,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sensor_out,
    output logic             s2,
    output logic             s3,
    output logic [CNT_W-1:0] dividend,
    output logic [CNT_W-1:0] divisor,
    output logic             per_on,
    input  logic             per_done,
    input  logic [PCT_W-1:0] percentage,
    output logic [PCT_W-1:0] red_pct,
    output logic [PCT_W-1:0] green_pct,
    output logic [PCT_W-1:0] blue_pct,
    output logic [CNT_W-1:0] clear_count,
    output logic             frame_valid,
    output logic             err
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ?
                          GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT      = CNT_W'(CNT_SAT);

    state_e           state_q, state_d;
    chan_e            ch_q, ch_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [PCT_W-1:0] pct_q [1:3];
    logic [PCT_W-1:0] pct_d [1:3];
    logic [PCT_W-1:0] red_q, red_d;
    logic [PCT_W-1:0] green_q, green_d;
    logic [PCT_W-1:0] blue_q, blue_d;
    logic [CNT_W-1:0] clear_q, clear_d;
    logic             fv_q, fv_d;
    logic             sens_rise;
    logic             to_hit;

    sensor_edge_sync u_sync (
        .clk     (CLK100MHZ),
        .rst_n   (reset_n),
        .async_i (sensor_out),
        .rise_o  (sens_rise)
    );

`ifdef COLOR_TIMEOUT_EN
    localparam int TOW = $clog2(PER_TIMEOUT + 1);

    logic [TOW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    assign to_hit = (state_q == ST_CALC) &&
                    (wd_q == TOW'(PER_TIMEOUT - 1));

    // Watchdog restarts on every CALC entry; err stays set until reset
    always_comb begin
        wd_d  = '0;
        err_d = err_q | (to_hit & ~per_done);
        if (state_q == ST_CALC) begin
            wd_d = wd_q + TOW'(1);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = |PER_TIMEOUT;
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ch_q    <= CH_CLEAR;
            tmr_q   <= '0;
            cnt_q   <= '{default: '0};
            pct_q   <= '{default: '0};
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            clear_q <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            pct_q   <= pct_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            clear_q <= clear_d;
            fv_q    <= fv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        pct_d   = pct_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SETTLE;
                    ch_d    = CH_CLEAR;
                    tmr_d   = '0;
                end
            end
            ST_SETTLE: begin
                cnt_d[ch_q] = '0;
                tmr_d       = tmr_q + TW'(1);
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_GATE;
                    tmr_d   = '0;
                end
            end
            ST_GATE: begin
                if (sens_rise && (cnt_q[ch_q] < SAT)) begin
                    cnt_d[ch_q] = cnt_q[ch_q] + CNT_W'(1);
                end
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == GATE_LAST) begin
                    tmr_d = '0;
                    if (ch_q != CH_BLUE) begin
                        state_d = ST_SETTLE;
                        ch_d    = chan_e'(ch_q + 2'd1);
                    end else if (cnt_q[CH_CLEAR] == '0) begin
                        // No reference light: nothing to divide by
                        state_d         = ST_PUBLISH;
                        pct_d[CH_RED]   = '0;
                        pct_d[CH_GREEN] = '0;
                        pct_d[CH_BLUE]  = '0;
                    end else begin
                        state_d = ST_CALC;
                        ch_d    = CH_RED;
                    end
                end
            end
            ST_CALC: begin
                if (per_done) begin
                    pct_d[ch_q] = percentage;
                    state_d     = ST_PER_OFF;
                end else if (to_hit) begin
                    pct_d[ch_q] = PCT_TIMEOUT;
                    state_d     = ST_PER_OFF;
                end
            end
            ST_PER_OFF: begin
                if (ch_q != CH_BLUE) begin
                    state_d = ST_CALC;
                    ch_d    = chan_e'(ch_q + 2'd1);
                end else begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                ch_d    = CH_CLEAR;
                state_d = enable ? ST_SETTLE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        clear_d = clear_q;
        fv_d    = 1'b0;
        if (state_q == ST_PUBLISH) begin
            red_d   = pct_q[CH_RED];
            green_d = pct_q[CH_GREEN];
            blue_d  = pct_q[CH_BLUE];
            clear_d = cnt_q[CH_CLEAR];
            fv_d    = 1'b1;
        end
    end

    always_comb begin
        {s2, s3} = SEL_CLEAR;
        per_on   = 1'b0;
        dividend = '0;
        divisor  = '0;
        unique case (state_q)
            ST_SETTLE, ST_GATE: {s2, s3} = filter_sel(ch_q);
            ST_CALC: begin
                per_on   = 1'b1;
                dividend = cnt_q[ch_q];
                divisor  = cnt_q[CH_CLEAR];
            end
            default: ;
        endcase
    end

    assign red_pct     = red_q;
    assign green_pct   = green_q;
    assign blue_pct    = blue_q;
    assign clear_count = clear_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_color_frame_sequencer.sv
// Bench for color_frame_sequencer: filter-driven sensor model, 5-cycle
// percentage calculator model, fixed vectors, random frames and corner cases.
module tb_color_frame_sequencer;

    localparam int GATE   = 1000;
    localparam int SETTLE = 10;
    localparam int SAT    = 300;
    localparam int TMO    = 64;
    localparam int LAT    = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sensor_out;
    logic        s2, s3;
    logic [20:0] dividend, divisor, clear_count;
    logic        per_on, per_done;
    logic [9:0]  percentage, red_pct, green_pct, blue_pct;
    logic        frame_valid, err;

    color_frame_sequencer #(
        .GATE_CYCLES   (GATE),
        .SETTLE_CYCLES (SETTLE),
        .CNT_SAT       (SAT),
        .PER_TIMEOUT   (TMO)
    ) dut (
        .CLK100MHZ   (clk),
        .reset_n     (rst_n),
        .enable      (enable),
        .sensor_out  (sensor_out),
        .s2          (s2),
        .s3          (s3),
        .dividend    (dividend),
        .divisor     (divisor),
        .per_on      (per_on),
        .per_done    (per_done),
        .percentage  (percentage),
        .red_pct     (red_pct),
        .green_pct   (green_pct),
        .blue_pct    (blue_pct),
        .clear_count (clear_count),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Sensor: period per filter (index clear, red, green, blue); <2 = stuck low
    int per [4] = '{0, 0, 0, 0};
    int ph = 0;
    int cur_p;

    function automatic int sel2ch(input logic [1:0] s);
        case (s)
            2'b10:   return 0;
            2'b00:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(negedge clk) begin
        cur_p = per[sel2ch({s2, s3})];
        if (cur_p < 2) begin
            sensor_out = 1'b0;
        end else begin
            ph = (ph + 1) % cur_p;
            sensor_out = (ph < cur_p / 2);
        end
    end

    // Calculator: 0 = 5-cycle latency, 1 = done always high, 2 = never done
    int   mode = 0;
    int   lat_cnt = 0;
    logic done_q = 1'b0;

    always @(posedge clk) begin
        if (!per_on) begin
            lat_cnt <= 0;
            done_q  <= 1'b0;
        end else if (lat_cnt == LAT - 1) begin
            done_q <= 1'b1;
        end else begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    assign per_done   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : done_q;
    assign percentage = (per_on && divisor != 0) ?
                        10'((int'(dividend) * 100) / int'(divisor)) : 10'd0;

    // Per-frame observation
    bit         mon_on = 0;
    int         fv_cnt, on_rises, gap_min, gap_max, low_run;
    logic       on_prev;
    logic [1:0] sel_q [$];

    always @(negedge clk) begin
        if (mon_on) begin
            if (frame_valid) fv_cnt++;
            if ({s2, s3} != sel_q[$]) sel_q.push_back({s2, s3});
            if (per_on && !on_prev) begin
                on_rises++;
                if (on_rises > 1) begin
                    if (low_run < gap_min) gap_min = low_run;
                    if (low_run > gap_max) gap_max = low_run;
                end
            end
            if (!per_on) low_run++;
            else low_run = 0;
            on_prev = per_on;
        end
    end

    task automatic start_stats();
        fv_cnt   = 0;
        on_rises = 0;
        gap_min  = 1 << 30;
        gap_max  = 0;
        low_run  = 0;
        on_prev  = 1'b0;
        sel_q.delete();
        sel_q.push_back({s2, s3});
        mon_on   = 1;
    endtask

    task automatic chk(input string nm, input int act,
                       input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One frame from IDLE: enable pulsed for one cycle, then dropped
    task automatic run_frame(input int pc, input int pr, input int pg,
                             input int pb, input int md, output bit ok);
        per  = '{pc, pr, pg, pb};
        mode = md;
        @(negedge clk);
        start_stats();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        ok = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                ok = 1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        mon_on = 0;
    endtask

    function automatic int sel_word();
        int v = 0;
        foreach (sel_q[i]) v = v * 4 + int'(sel_q[i]);
        return v;
    endfunction

    // Edge count range over one gate window for a given sensor period
    task automatic cnt_rng(input int p, output int lo, output int hi);
        int q;
        if (p < 2) begin
            lo = 0;
            hi = 0;
        end else begin
            q = GATE / p;
            if (q > SAT) begin
                lo = SAT;
                hi = SAT;
            end else if (GATE % p == 0) begin
                lo = q;
                hi = q;
            end else begin
                lo = q;
                hi = (q + 1 > SAT) ? SAT : q + 1;
            end
        end
    endtask

    typedef struct {
        int pc, pr, pg, pb;
        int md;
        int clr, r, g, b;
        int tol;
    } vec_t;

    localparam int SEL_SEQ = int'(10'b10_00_11_01_10);

    initial begin
        vec_t tv [4];
        bit   ok;
        int   klo, khi, lo, hi, plo, phi, n;
        int   rp [4];

        tv[0] = '{10, 40, 20, 100, 0, 100, 25, 50, 10, 1};
        tv[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[2] = '{2, 2, 2, 2, 0, 300, 100, 100, 100, 0};
        tv[3] = '{10, 40, 20, 100, 1, 100, 25, 50, 10, 1};

        rst_n  = 1'b1;
        enable = 1'b0;
        #2 rst_n = 1'b0;
        #30;
        chk("rst_s2s3", int'({s2, s3}), 2, 2);
        chk("rst_per_on", int'(per_on), 0, 0);
        chk("rst_fv", int'(frame_valid), 0, 0);
        chk("rst_pct", int'(red_pct | green_pct | blue_pct), 0, 0);
        chk("rst_clear", int'(clear_count), 0, 0);
        chk("rst_err", int'(err), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run_frame(tv[v].pc, tv[v].pr, tv[v].pg, tv[v].pb, tv[v].md, ok);
            chk($sformatf("v%0d_frame_seen", v), int'(ok), 1, 1);
            chk($sformatf("v%0d_fv_pulses", v), fv_cnt, 1, 1);
            chk($sformatf("v%0d_clear", v), int'(clear_count),
                tv[v].clr - tv[v].tol, tv[v].clr + tv[v].tol);
            chk($sformatf("v%0d_red", v), int'(red_pct),
                tv[v].r - tv[v].tol, tv[v].r + tv[v].tol);
            chk($sformatf("v%0d_green", v), int'(green_pct),
                tv[v].g - tv[v].tol, tv[v].g + tv[v].tol);
            chk($sformatf("v%0d_blue", v), int'(blue_pct),
                tv[v].b - tv[v].tol, tv[v].b + tv[v].tol);
            chk($sformatf("v%0d_sel_len", v), sel_q.size(), 5, 5);
            chk($sformatf("v%0d_sel_seq", v), sel_word(), SEL_SEQ, SEL_SEQ);
            chk($sformatf("v%0d_per_on_cnt", v), on_rises,
                (tv[v].clr == 0) ? 0 : 3, (tv[v].clr == 0) ? 0 : 3);
            if (on_rises == 3) begin
                chk($sformatf("v%0d_gap_min", v), gap_min, 1, 1);
                chk($sformatf("v%0d_gap_max", v), gap_max, 1, 1);
            end
            chk($sformatf("v%0d_err", v), int'(err), 0, 0);
        end

        for (int f = 0; f < 3; f++) begin
            rp[0] = int'($urandom_range(12, 2));
            for (int c = 1; c < 4; c++) rp[c] = int'($urandom_range(60, rp[0]));
            run_frame(rp[0], rp[1], rp[2], rp[3], 0, ok);
            cnt_rng(rp[0], klo, khi);
            chk($sformatf("rnd%0d_frame_seen", f), int'(ok), 1, 1);
            chk($sformatf("rnd%0d_clear", f), int'(clear_count), klo, khi);
            for (int c = 1; c < 4; c++) begin
                cnt_rng(rp[c], lo, hi);
                plo = lo * 100 / khi;
                phi = hi * 100 / klo;
                chk($sformatf("rnd%0d_pct%0d", f, c),
                    (c == 1) ? int'(red_pct) :
                    (c == 2) ? int'(green_pct) : int'(blue_pct), plo, phi);
            end
        end

`ifdef COLOR_TIMEOUT_EN
        run_frame(10, 40, 20, 100, 2, ok);
        chk("to_frame_seen", int'(ok), 1, 1);
        chk("to_red", int'(red_pct), 1023, 1023);
        chk("to_green", int'(green_pct), 1023, 1023);
        chk("to_blue", int'(blue_pct), 1023, 1023);
        chk("to_err", int'(err), 1, 1);
        chk("to_clear", int'(clear_count), 100, 100);
`else
        per  = '{10, 40, 20, 100};
        mode = 2;
        @(negedge clk);
        start_stats();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (per_on) begin
                ok = 1;
                break;
            end
        end
        repeat (200) @(negedge clk);
        mon_on = 0;
        chk("hold_per_on_seen", int'(ok), 1, 1);
        chk("hold_per_on", int'(per_on), 1, 1);
        chk("hold_dividend", int'(dividend), 25, 25);
        chk("hold_divisor", int'(divisor), 100, 100);
        chk("hold_no_frame", fv_cnt, 0, 0);
        chk("hold_err", int'(err), 0, 0);
`endif
        mode = 0;
        apply_reset();
        chk("post_rst_err", int'(err), 0, 0);

        run_frame(10, 40, 20, 100, 0, ok);
        chk("pre6_red", int'(red_pct), 25, 25);

        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if ({s2, s3} == 2'b11) begin
                ok = 1;
                break;
            end
        end
        chk("r6_green_seen", int'(ok), 1, 1);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("r6_s2s3", int'({s2, s3}), 2, 2);
        chk("r6_per_on", int'(per_on), 0, 0);
        chk("r6_fv", int'(frame_valid), 0, 0);
        chk("r6_red", int'(red_pct), 0, 0);
        chk("r6_green_blue", int'(green_pct | blue_pct), 0, 0);
        chk("r6_clear", int'(clear_count), 0, 0);
        chk("r6_dividend", int'(dividend), 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (i == 1) chk("r6_restart_clear", int'({s2, s3}), 2, 2);
            if ({s2, s3} == 2'b00) begin
                n = i;
                break;
            end
        end
        chk("r6_red_start", n, 1 + SETTLE + GATE, 1 + SETTLE + GATE);
        enable = 1'b0;
        ok = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                ok = 1;
                break;
            end
        end
        chk("r6_frame_seen", int'(ok), 1, 1);
        chk("r6_frame_clear", int'(clear_count), 100, 100);
        chk("r6_frame_red", int'(red_pct), 25, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
